// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares BRAM port B between the SIMD core (requester 0) and the
// writeback/debug unit (requester 1). Define BRAM_ARB_RR_EN for round-robin conflicts.
module bram_port_arbiter #(
  parameter int unsigned AW     = 13,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic [3:0]    WE0,
  input  logic [3:0]    WE1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA0,
  input  logic [DW-1:0] WDATA1,
  output logic          GNT0,
  output logic          GNT1,
  output logic          RVALID0,
  output logic          RVALID1,
  output logic [DW-1:0] RDATA0,
  output logic [DW-1:0] RDATA1,
  output logic [AW-1:0] addrb,
  output logic [DW-1:0] dinb,
  input  logic [DW-1:0] doutb,
  output logic          enb,
  output logic [3:0]    web,
  output logic          BUSY
);

`ifdef BRAM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  logic              last;
  logic              gnt0_c;
  logic              gnt1_c;
  logic              gnt_any_c;
  logic              pick1_c;
  logic [3:0]        sel_we_c;
  logic [AW-1:0]     sel_addr_c;
  logic [DW-1:0]     sel_wdata_c;
  logic              rd_issue_c;
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_own;
  logic [RD_LAT-1:0] pipe_vld_n;
  logic [RD_LAT-1:0] pipe_own_n;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [DW-1:0]     rdata0_q;
  logic [DW-1:0]     rdata1_q;
  logic              busy_q;

  // Conflict winner: under round-robin the requester that was not granted last.
  always_comb begin
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    pick1_c = RR_EN & ~last;
    if (RSTN) begin
      if (REQ0 && REQ1) begin
        gnt0_c = ~pick1_c;
        gnt1_c = pick1_c;
      end else begin
        gnt0_c = REQ0;
        gnt1_c = REQ1;
      end
    end
  end

  assign gnt_any_c = gnt0_c | gnt1_c;
  assign GNT0      = gnt0_c;
  assign GNT1      = gnt1_c;

  // Mux of the granted requester's access; byte enables are zero when idle.
  always_comb begin
    sel_we_c    = 4'h0;
    sel_addr_c  = ADDR0;
    sel_wdata_c = WDATA0;
    if (gnt1_c) begin
      sel_we_c    = WE1;
      sel_addr_c  = ADDR1;
      sel_wdata_c = WDATA1;
    end else if (gnt0_c) begin
      sel_we_c    = WE0;
    end
  end

  assign rd_issue_c = gnt_any_c && (sel_we_c == 4'h0);

  // Read tracking shift register: valid + owner per stage, stage 0 aligned with enb.
  always_comb begin
    pipe_vld_n = (pipe_vld << 1) | RD_LAT'(rd_issue_c);
    pipe_own_n = (pipe_own << 1) | RD_LAT'(gnt1_c);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      enb       <= 1'b0;
      web       <= 4'h0;
      addrb     <= '0;
      dinb      <= '0;
      last      <= 1'b1;
      pipe_vld  <= '0;
      pipe_own  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      enb       <= gnt_any_c;
      web       <= sel_we_c;
      if (gnt_any_c) begin
        addrb <= sel_addr_c;
        dinb  <= sel_wdata_c;
        last  <= gnt1_c;
      end
      pipe_vld  <= pipe_vld_n;
      pipe_own  <= pipe_own_n;
      rvalid0_q <= pipe_vld[RD_LAT-1] & ~pipe_own[RD_LAT-1];
      rvalid1_q <= pipe_vld[RD_LAT-1] &  pipe_own[RD_LAT-1];
      if (rvalid0_q) rdata0_q <= doutb;
      if (rvalid1_q) rdata1_q <= doutb;
      busy_q    <= gnt_any_c | (|pipe_vld_n);
    end
  end

  // doutb is live in the return cycle; the hold registers keep it afterwards.
  assign RVALID0 = rvalid0_q;
  assign RVALID1 = rvalid1_q;
  assign RDATA0  = rvalid0_q ? doutb : rdata0_q;
  assign RDATA1  = rvalid1_q ? doutb : rdata1_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: two instances (RD_LAT=1 and RD_LAT=2) share stimulus,
// each with its own BRAM model; read returns are checked against a scoreboard.
module tb_bram_port_arbiter;
  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] data;
    logic [31:0]   cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req0, req1;
  logic [3:0]    we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic          gnt0_v   [2];
  logic          gnt1_v   [2];
  logic          rv0_v    [2];
  logic          rv1_v    [2];
  logic [DW-1:0] rd0_v    [2];
  logic [DW-1:0] rd1_v    [2];
  logic [AW-1:0] addrb_v  [2];
  logic [DW-1:0] dinb_v   [2];
  logic [DW-1:0] doutb_v  [2];
  logic          enb_v    [2];
  logic [3:0]    web_v    [2];
  logic          busy_v   [2];

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  exp_t          q0[$];
  exp_t          q1[$];
  int            pass_cnt  = 0;
  int            total_cnt = 0;
  int unsigned   cyc = 0;
  logic          gv0, gv1;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int unsigned a);
    return (a == 32'h10) ? 32'hDEADBEEF : (32'hC0DE_0000 | a);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] dq1, dq2;

    initial for (int unsigned i = 0; i < (1 << AW); i++) mem[i] = init_word(i);

    always @(posedge clk) begin
      if (enb_v[g]) begin
        if (web_v[g] == 4'h0) dq1 <= mem[addrb_v[g]];
        for (int b = 0; b < 4; b++)
          if (web_v[g][b]) mem[addrb_v[g]][8*b +: 8] <= dinb_v[g][8*b +: 8];
      end
      dq2 <= dq1;
    end
    assign doutb_v[g] = (g == 0) ? dq1 : dq2;

    bram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(g + 1)) u_dut (
      .CLK    (clk),
      .RSTN   (rstn),
      .REQ0   (req0),
      .REQ1   (req1),
      .WE0    (we0),
      .WE1    (we1),
      .ADDR0  (addr0),
      .ADDR1  (addr1),
      .WDATA0 (wdata0),
      .WDATA1 (wdata1),
      .GNT0   (gnt0_v[g]),
      .GNT1   (gnt1_v[g]),
      .RVALID0(rv0_v[g]),
      .RVALID1(rv1_v[g]),
      .RDATA0 (rd0_v[g]),
      .RDATA1 (rd1_v[g]),
      .addrb  (addrb_v[g]),
      .dinb   (dinb_v[g]),
      .doutb  (doutb_v[g]),
      .enb    (enb_v[g]),
      .web    (web_v[g]),
      .BUSY   (busy_v[g])
    );
  end

  // Record an accepted request: reads queue an expected return, writes update the model.
  task automatic accept(input logic owner, input logic [3:0] we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    if (we == 4'h0) begin
      e.owner = owner;
      e.data  = ref_mem[a];
      e.cyc   = cyc + 2;
      q0.push_back(e);
      e.cyc   = cyc + 3;
      q1.push_back(e);
    end else begin
      for (int b = 0; b < 4; b++)
        if (we[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Falling-edge sample: capture grants and score any read return.
  task automatic sample_cycle();
    exp_t          e;
    logic [DW-1:0] got;
    @(negedge clk);
    gv0 = gnt0_v[0];
    gv1 = gnt1_v[0];
    if (gv0 === 1'b1) accept(1'b0, we0, addr0, wdata0);
    if (gv1 === 1'b1) accept(1'b1, we1, addr1, wdata1);
    for (int i = 0; i < 2; i++) begin
      if (rv0_v[i] === 1'b1 || rv1_v[i] === 1'b1) begin
        total_cnt++;
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          $display("FAIL scoreboard_unexpected inst%0d cyc %0d: rvalid0=%b rvalid1=%b, required no return",
                   i, cyc, rv0_v[i], rv1_v[i]);
        end else begin
          if (i == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          got = e.owner ? rd1_v[i] : rd0_v[i];
          if (rv0_v[i] !== ~e.owner || rv1_v[i] !== e.owner || got !== e.data || cyc !== e.cyc)
            $display("FAIL scoreboard_return inst%0d: rv0=%b rv1=%b data=%h cyc=%0d, required owner=%0d data=%h cyc=%0d",
                     i, rv0_v[i], rv1_v[i], got, cyc, e.owner, e.data, e.cyc);
          else
            pass_cnt++;
        end
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      sample_cycle();
      next_cycle();
    end
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    tick(2);
    q0.delete();
    q1.delete();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req0 = 1'b1; req1 = 1'b1; we0 = 4'h0; we1 = 4'h0;
    addr0 = 13'h5; addr1 = 13'h6; wdata0 = '0; wdata1 = '0;
    for (int c = 0; c < 2; c++) begin
      sample_cycle();
      for (int i = 0; i < 2; i++) begin
        total_cnt++;
        if ({gnt0_v[i], gnt1_v[i]} !== 2'b00)
          $display("FAIL reset_gnt inst%0d: got %b, required 00", i, {gnt0_v[i], gnt1_v[i]});
        else pass_cnt++;
        if (c == 1) begin
          total_cnt++;
          if ({rv0_v[i], rv1_v[i], enb_v[i], busy_v[i]} !== 4'b0000)
            $display("FAIL reset_ctrl inst%0d: rv0/rv1/enb/busy=%b, required 0000", i,
                     {rv0_v[i], rv1_v[i], enb_v[i], busy_v[i]});
          else pass_cnt++;
          total_cnt++;
          if (web_v[i] !== 4'h0)
            $display("FAIL reset_web inst%0d: got %h, required 0", i, web_v[i]);
          else pass_cnt++;
          total_cnt++;
          if ({addrb_v[i], dinb_v[i]} !== '0)
            $display("FAIL reset_addr_din inst%0d: addrb=%h dinb=%h, required 0", i, addrb_v[i], dinb_v[i]);
          else pass_cnt++;
          total_cnt++;
          if ({rd0_v[i], rd1_v[i]} !== '0)
            $display("FAIL reset_rdata inst%0d: rdata0=%h rdata1=%h, required 0", i, rd0_v[i], rd1_v[i]);
          else pass_cnt++;
        end
      end
      next_cycle();
    end
    rstn = 1'b1; req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_single_read();
    req1 = 1'b1; we1 = 4'h0; addr1 = 13'h0010;
    sample_cycle();
    total_cnt++;
    if ({gv0, gv1} !== 2'b01) $display("FAIL single_read_gnt: got %b, required 01", {gv0, gv1});
    else pass_cnt++;
    next_cycle();
    req1 = 1'b0;
    sample_cycle();
    total_cnt++;
    if ({enb_v[0], web_v[0], addrb_v[0]} !== {1'b1, 4'h0, 13'h0010})
      $display("FAIL single_read_issue: enb=%b web=%h addrb=%h, required 1 0 0010", enb_v[0], web_v[0], addrb_v[0]);
    else pass_cnt++;
    next_cycle();
    sample_cycle();
    total_cnt++;
    if ({rv0_v[0], rv1_v[0]} !== 2'b01 || rd1_v[0] !== 32'hDEADBEEF)
      $display("FAIL single_read_return: rv0/rv1=%b rdata1=%h, required 01 deadbeef", {rv0_v[0], rv1_v[0]}, rd1_v[0]);
    else pass_cnt++;
    total_cnt++;
    if (rd0_v[0] !== 32'h0) $display("FAIL single_read_rdata0_hold: got %h, required 0", rd0_v[0]);
    else pass_cnt++;
    next_cycle();
    tick(3);
  endtask

  task automatic test_write_read();
    req0 = 1'b1; we0 = 4'hF; addr0 = 13'h1FFF; wdata0 = 32'h12345678;
    sample_cycle();
    total_cnt++;
    if ({gv0, gv1} !== 2'b10) $display("FAIL write_gnt: got %b, required 10", {gv0, gv1});
    else pass_cnt++;
    next_cycle();
    we0 = 4'h0;
    sample_cycle();
    total_cnt++;
    if ({enb_v[0], web_v[0], addrb_v[0], dinb_v[0]} !== {1'b1, 4'hF, 13'h1FFF, 32'h12345678})
      $display("FAIL write_issue: enb=%b web=%h addrb=%h dinb=%h, required 1 f 1fff 12345678",
               enb_v[0], web_v[0], addrb_v[0], dinb_v[0]);
    else pass_cnt++;
    next_cycle();
    req0 = 1'b0;
    tick(1);
    sample_cycle();
    total_cnt++;
    if (rv0_v[0] !== 1'b1 || rd0_v[0] !== 32'h12345678)
      $display("FAIL write_read_data: rvalid0=%b rdata0=%h, required 1 12345678", rv0_v[0], rd0_v[0]);
    else pass_cnt++;
    next_cycle();
    tick(3);
  endtask

  task automatic test_conflict();
    logic [1:0] exp;
    reset_dut();
    req0 = 1'b1; req1 = 1'b1; we0 = 4'h0; we1 = 4'h0; addr0 = 13'h0020; addr1 = 13'h0021;
    for (int k = 0; k < 6; k++) begin
      sample_cycle();
`ifdef BRAM_ARB_RR_EN
      exp = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp = 2'b10;
`endif
      total_cnt++;
      if ({gv0, gv1} !== exp) $display("FAIL conflict_gnt[%0d]: got %b, required %b", k, {gv0, gv1}, exp);
      else pass_cnt++;
      next_cycle();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(5);
  endtask

  task automatic test_interleaved();
    int unsigned tg;
    req0 = 1'b1; we0 = 4'h0; addr0 = 13'h0001;
    sample_cycle();
    total_cnt++;
    if ({gv0, gv1} !== 2'b10) $display("FAIL interleave_gnt0: got %b, required 10", {gv0, gv1});
    else pass_cnt++;
    next_cycle();
    req0 = 1'b0; req1 = 1'b1; we1 = 4'h0; addr1 = 13'h0002;
    sample_cycle();
    tg = cyc;
    total_cnt++;
    if ({gv0, gv1} !== 2'b01) $display("FAIL interleave_gnt1: got %b, required 01", {gv0, gv1});
    else pass_cnt++;
    next_cycle();
    req1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      sample_cycle();
      if (k <= 2) begin
        total_cnt++;
        if (busy_v[1] !== 1'b1) $display("FAIL interleave_busy cyc tg+%0d: got %b, required 1", k, busy_v[1]);
        else pass_cnt++;
      end
      if (k == 2) begin
        total_cnt++;
        if ({rv0_v[1], rv1_v[1]} !== 2'b10 || rd0_v[1] !== init_word(1))
          $display("FAIL interleave_ret0: rv0/rv1=%b rdata0=%h, required 10 %h", {rv0_v[1], rv1_v[1]}, rd0_v[1], init_word(1));
        else pass_cnt++;
      end
      if (k == 3) begin
        total_cnt++;
        if ({rv0_v[1], rv1_v[1]} !== 2'b01 || rd1_v[1] !== init_word(2))
          $display("FAIL interleave_ret1: rv0/rv1=%b rdata1=%h, required 01 %h", {rv0_v[1], rv1_v[1]}, rd1_v[1], init_word(2));
        else pass_cnt++;
      end
      next_cycle();
    end
    sample_cycle();
    total_cnt++;
    if ({busy_v[0], busy_v[1]} !== 2'b00)
      $display("FAIL interleave_busy_idle cyc %0d (grant %0d): got %b, required 00", cyc, tg, {busy_v[0], busy_v[1]});
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_reset_mid_flight();
    req1 = 1'b1; we1 = 4'h0; addr1 = 13'h0010;
    sample_cycle();
    total_cnt++;
    if ({gv0, gv1} !== 2'b01) $display("FAIL midreset_gnt: got %b, required 01", {gv0, gv1});
    else pass_cnt++;
    next_cycle();
    req1 = 1'b0; rstn = 1'b0;
    q0.delete();
    q1.delete();
    tick(1);
    rstn = 1'b1;
    sample_cycle();
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if ({rv0_v[i], rv1_v[i], enb_v[i], busy_v[i], web_v[i]} !== 8'h00 ||
          {addrb_v[i], dinb_v[i], rd0_v[i], rd1_v[i]} !== '0)
        $display("FAIL midreset_outputs inst%0d: rv=%b%b enb=%b busy=%b web=%h addrb=%h dinb=%h rd0=%h rd1=%h, required all 0",
                 i, rv0_v[i], rv1_v[i], enb_v[i], busy_v[i], web_v[i], addrb_v[i], dinb_v[i], rd0_v[i], rd1_v[i]);
      else pass_cnt++;
    end
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      sample_cycle();
      total_cnt++;
      if ({rv0_v[0], rv1_v[0], rv0_v[1], rv1_v[1]} !== 4'b0000)
        $display("FAIL midreset_no_rvalid[%0d]: got %b, required 0000", k, {rv0_v[0], rv1_v[0], rv0_v[1], rv1_v[1]});
      else pass_cnt++;
      next_cycle();
    end
    req0 = 1'b1; req1 = 1'b1; we0 = 4'h0; we1 = 4'h0; addr0 = 13'h0030; addr1 = 13'h0031;
    sample_cycle();
    total_cnt++;
    if ({gv0, gv1} !== 2'b10) $display("FAIL midreset_first_conflict: got %b, required 10", {gv0, gv1});
    else pass_cnt++;
    next_cycle();
    req0 = 1'b0;
    sample_cycle();
    total_cnt++;
    if ({gv0, gv1} !== 2'b01) $display("FAIL midreset_second_gnt: got %b, required 01", {gv0, gv1});
    else pass_cnt++;
    next_cycle();
    req1 = 1'b0;
    tick(5);
  endtask

  task automatic test_write_burst();
    req1 = 1'b1; we1 = 4'hF;
    for (int k = 0; k < 4; k++) begin
      addr1  = 13'h0100 + 13'(k);
      wdata1 = 32'hA000_0000 + 32'(k);
      sample_cycle();
      total_cnt++;
      if (gv1 !== 1'b1 || (k > 0 && enb_v[0] !== 1'b1))
        $display("FAIL burst_write[%0d]: gnt1=%b enb=%b, required 1 1", k, gv1, enb_v[0]);
      else pass_cnt++;
      next_cycle();
    end
    req1 = 1'b0;
    sample_cycle();
    total_cnt++;
    if ({enb_v[0], busy_v[0]} !== 2'b11) $display("FAIL burst_last_enb: enb/busy=%b, required 11", {enb_v[0], busy_v[0]});
    else pass_cnt++;
    next_cycle();
    sample_cycle();
    total_cnt++;
    if ({enb_v[0], busy_v[0], rv0_v[0], rv1_v[0]} !== 4'b0000)
      $display("FAIL burst_busy_fall: enb/busy/rv0/rv1=%b, required 0000", {enb_v[0], busy_v[0], rv0_v[0], rv1_v[0]});
    else pass_cnt++;
    next_cycle();
    req0 = 1'b1; we0 = 4'h0; addr0 = 13'h0102;
    sample_cycle();
    next_cycle();
    req0 = 1'b0;
    tick(5);
  endtask

  initial begin
    for (int unsigned i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    test_reset();
    test_single_read();
    test_write_read();
    test_conflict();
    test_interleaved();
    test_reset_mid_flight();
    test_write_burst();
    total_cnt++;
    if (q0.size() != 0 || q1.size() != 0)
      $display("FAIL scoreboard_drain: pending inst0=%0d inst1=%0d, required 0 0", q0.size(), q1.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
